// File: rtl/coherence_pkg.sv
// Shared types and sizing for the two-cache MESI bus controller.
package coherence_pkg;

    localparam int N_CACHES   = 2;
    localparam int BLOCK_SIZE = 2;
    localparam int N_SETS     = 64;
    localparam int SB         = $clog2(N_SETS);
    localparam int WB         = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        MODIFIED  = 2'd0,
        EXCLUSIVE = 2'd1,
        SHARED    = 2'd2,
        INVALID   = 2'd3
    } cc_end_state;

    typedef enum logic [2:0] {
        IDLE,
        SNOOP,
        SNOOP_RESP,
        C2C,
        MEM_FILL,
        GRANT
    } cc_fsm_t;

    // Byte address of word w inside the block starting at base.
    function automatic word_t word_addr(input word_t base, input logic [WB-1:0] w);
        return base + word_t'({w, 2'b00});
    endfunction

endpackage

// File: rtl/coherence_arbiter.sv
// Two-way round-robin pick between pending cache miss requests.
module coherence_arbiter (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_id,
    output logic       gnt_valid
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = 1'b0;
        if (&req) begin
            gnt_id = ~last_grant;
        end else begin
            gnt_id = req[1];
        end
    end

endmodule

// File: rtl/coherence_unit.sv
// MESI bus controller for two caches: arbitrate, snoop peer, source block, issue final states.
// Optional COHERENCE_PERF_EN adds saturating event counters for c2c, memory fills and invalidations.
module coherence_unit
    import coherence_pkg::*;
(
    input  logic                CLK,
    input  logic                nRST,
    input  logic [N_CACHES-1:0] req,
    input  logic [N_CACHES-1:0] write_req,
    input  logic [SB-1:0]       req_set        [N_CACHES-1:0],
    input  word_t               req_tag        [N_CACHES-1:0],
    input  logic [N_CACHES-1:0] valid,
    input  logic [N_CACHES-1:0] exclusive,
    input  logic [N_CACHES-1:0] dirty,
    input  logic [N_CACHES-1:0] snoop_hit,
    input  word_t               frame_tag      [N_CACHES-1:0],
    input  word_t               requested_data [N_CACHES-1:0],
    input  logic [N_CACHES-1:0] dWEN,
    output logic [SB-1:0]       set_sel        [N_CACHES-1:0],
    output logic [WB-1:0]       word_sel       [N_CACHES-1:0],
    output logic [N_CACHES-1:0] snoop_req,
    output word_t               responder_data [N_CACHES-1:0],
    output logic [N_CACHES-1:0] fill_wen,
    output cc_end_state         state_transfer [N_CACHES-1:0],
    output logic [N_CACHES-1:0] done,
`ifdef COHERENCE_PERF_EN
    output logic [31:0]         c2c_count,
    output logic [31:0]         mem_fill_count,
    output logic [31:0]         inval_count,
`endif
    output logic                mem_ren,
    output logic                mem_wen,
    output word_t               mem_addr,
    output word_t               mem_wdata,
    input  word_t               mem_rdata,
    input  logic                mem_busy
);

    cc_fsm_t             state_reg;
    logic                req_id_reg;
    logic                last_grant_reg;
    logic                write_reg;
    logic                hit_reg;
    logic                dirty_reg;
    word_t               tag_reg;
    logic [SB-1:0]       set_reg;
    logic [WB-1:0]       word_cnt_reg;
    logic [N_CACHES-1:0] snoop_req_reg;
    logic [N_CACHES-1:0] done_reg;
    cc_end_state         st_reg [N_CACHES-1:0];
    logic                mem_ren_reg;
    logic                mem_wen_reg;
    word_t               mem_addr_reg;

    logic  gnt_id;
    logic  gnt_valid;
    logic  peer_id;
    logic  peer_hit;
    logic  peer_dirty;
    logic  filling;
    logic  beat_ok;
    logic  last_beat;
    word_t fill_data;

    // Exclusivity and the frame tag are informational only; the hit decision uses snoop_hit.
    logic unused_snoop_info;
    assign unused_snoop_info = ^{exclusive, frame_tag[0], frame_tag[1]};

    coherence_arbiter u_arb (
        .req        (req),
        .last_grant (last_grant_reg),
        .gnt_id     (gnt_id),
        .gnt_valid  (gnt_valid)
    );

    assign peer_id    = ~req_id_reg;
    assign peer_hit   = snoop_hit[peer_id] & valid[peer_id];
    assign peer_dirty = dirty[peer_id] | dWEN[peer_id];
    assign filling    = (state_reg == C2C) || (state_reg == MEM_FILL);
    // Any beat that touches memory completes only on a cycle where memory is not stalling.
    assign beat_ok    = ((state_reg == MEM_FILL) || dirty_reg) ? !mem_busy : 1'b1;
    assign last_beat  = filling && beat_ok && (word_cnt_reg == WB'(BLOCK_SIZE - 1));
    assign fill_data  = (state_reg == C2C) ? requested_data[peer_id] : mem_rdata;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg      <= IDLE;
            req_id_reg     <= 1'b0;
            last_grant_reg <= 1'b1;
            write_reg      <= 1'b0;
            hit_reg        <= 1'b0;
            dirty_reg      <= 1'b0;
            tag_reg        <= '0;
            set_reg        <= '0;
            word_cnt_reg   <= '0;
            snoop_req_reg  <= '0;
            done_reg       <= '0;
            mem_ren_reg    <= 1'b0;
            mem_wen_reg    <= 1'b0;
            mem_addr_reg   <= '0;
            for (int i = 0; i < N_CACHES; i++) begin
                st_reg[i] <= INVALID;
            end
        end else begin
            done_reg      <= '0;
            snoop_req_reg <= '0;
            unique case (state_reg)
                IDLE: begin
                    if (gnt_valid) begin
                        req_id_reg             <= gnt_id;
                        write_reg              <= write_req[gnt_id];
                        set_reg                <= req_set[gnt_id];
                        tag_reg                <= req_tag[gnt_id];
                        snoop_req_reg[~gnt_id] <= 1'b1;
                        state_reg              <= SNOOP;
                    end
                end
                SNOOP: begin
                    state_reg <= SNOOP_RESP;
                end
                SNOOP_RESP: begin
                    hit_reg      <= peer_hit;
                    dirty_reg    <= peer_hit & peer_dirty;
                    word_cnt_reg <= '0;
                    mem_addr_reg <= tag_reg;
                    if (peer_hit) begin
                        mem_wen_reg <= peer_dirty;
                        state_reg   <= C2C;
                    end else begin
                        mem_ren_reg <= 1'b1;
                        state_reg   <= MEM_FILL;
                    end
                end
                C2C, MEM_FILL: begin
                    if (last_beat) begin
                        state_reg            <= GRANT;
                        mem_ren_reg          <= 1'b0;
                        mem_wen_reg          <= 1'b0;
                        mem_addr_reg         <= '0;
                        word_cnt_reg         <= '0;
                        done_reg[req_id_reg] <= 1'b1;
                        last_grant_reg       <= req_id_reg;
                        if (write_reg) begin
                            st_reg[req_id_reg] <= MODIFIED;
                            if (hit_reg) begin
                                done_reg[peer_id] <= 1'b1;
                                st_reg[peer_id]   <= INVALID;
                            end
                        end else if (hit_reg) begin
                            st_reg[req_id_reg] <= SHARED;
                            st_reg[peer_id]    <= SHARED;
                            done_reg[peer_id]  <= 1'b1;
                        end else begin
                            st_reg[req_id_reg] <= EXCLUSIVE;
                        end
                    end else if (beat_ok) begin
                        word_cnt_reg <= word_cnt_reg + WB'(1);
                        mem_addr_reg <= word_addr(tag_reg, word_cnt_reg + WB'(1));
                    end
                end
                GRANT: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef COHERENCE_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            c2c_count      <= '0;
            mem_fill_count <= '0;
            inval_count    <= '0;
        end else if (last_beat) begin
            if (hit_reg) begin
                if (c2c_count != '1) c2c_count <= c2c_count + 32'd1;
            end else begin
                if (mem_fill_count != '1) mem_fill_count <= mem_fill_count + 32'd1;
            end
            if (write_reg && hit_reg && (inval_count != '1)) begin
                inval_count <= inval_count + 32'd1;
            end
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_CACHES; gi++) begin : g_port
            assign set_sel[gi]        = set_reg;
            assign word_sel[gi]       = word_cnt_reg;
            assign fill_wen[gi]       = filling && beat_ok && (int'(req_id_reg) == gi);
            assign responder_data[gi] = fill_wen[gi] ? fill_data : '0;
            assign state_transfer[gi] = st_reg[gi];
        end
    endgenerate

    assign snoop_req = snoop_req_reg;
    assign done      = done_reg;
    assign mem_ren   = mem_ren_reg;
    assign mem_wen   = mem_wen_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wen_reg ? requested_data[peer_id] : '0;

endmodule
